// File: rtl/nor_gate_pkg.sv
// Shared constants and helpers for the nor_gate block.
// Contents: default counter width, reset-value constants, saturating increment.
// Optional feature macro used by the top: NOR_GATE_STATS_EN.
package nor_gate_pkg;

   localparam int unsigned CNT_W_DEFAULT = 16;

   // Reset value of every bit of each registered output.
   localparam logic Y_Q_RST_BIT    = 1'b0;
   localparam logic Y_RISE_RST_BIT = 1'b0;
   localparam logic HI_CNT_RST_BIT = 1'b0;

   // Increment that sticks at max_value instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                           input logic [31:0] max_value);
      return (value >= max_value) ? max_value : value + 32'd1;
   endfunction

endpackage

// File: rtl/nor_gate_cell.sv
// One combinational NOR lane.
// Ports: a_i, b_i operands; y_o = ~(a_i | b_i).
module nor_gate_cell (
   input  logic a_i,
   input  logic b_i,
   output logic y_o
);

   // Plain Verilog semantics: a 1 on either input forces 0 even if the other is X/Z.
   assign y_o = ~(a_i | b_i);

endmodule

// File: rtl/nor_gate.sv
// Bitwise NOR with a registered copy, rising-edge detect and optional
// all-ones statistics counter.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   a, b          WIDTH-bit operands
//   y             combinational ~(a|b), independent of clk/rst
//   y_q           y registered once
//   all_one       combinational &y
//   y_rise        registered per-lane 0->1 pulse of y_q
//   hi_cnt        saturating count of cycles with all_one (NOR_GATE_STATS_EN),
//                 otherwise tied to zero
// Macro: NOR_GATE_STATS_EN enables the hi_cnt counter. CNT_W must be <= 32.
module nor_gate
   import nor_gate_pkg::*;
#(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] y_q,
   output logic             all_one,
   output logic [WIDTH-1:0] y_rise,
   output logic [CNT_W-1:0] hi_cnt
);

   logic [WIDTH-1:0] y_q_d;
   logic [WIDTH-1:0] y_rise_d;

   // Combinational lanes.
   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      nor_gate_cell u_cell (
         .a_i (a[i]),
         .b_i (b[i]),
         .y_o (y[i])
      );
   end

   assign all_one = &y;

   // Next state: y_rise compares the incoming y against the current y_q, so it
   // is high for the cycle right after y_q turns 1.
   always_comb begin
      y_q_d    = y;
      y_rise_d = y & ~y_q;
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         y_q    <= {WIDTH{Y_Q_RST_BIT}};
         y_rise <= {WIDTH{Y_RISE_RST_BIT}};
      end else begin
         y_q    <= y_q_d;
         y_rise <= y_rise_d;
      end
   end

`ifdef NOR_GATE_STATS_EN
   localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

   logic [CNT_W-1:0] hi_cnt_q;
   logic [CNT_W-1:0] hi_cnt_d;

   // Saturating count of all-lanes-true cycles.
   always_comb begin
      hi_cnt_d = hi_cnt_q;
      if (all_one) begin
         hi_cnt_d = CNT_W'(sat_inc(32'(hi_cnt_q), CNT_MAX));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_cnt_q <= {CNT_W{HI_CNT_RST_BIT}};
      end else begin
         hi_cnt_q <= hi_cnt_d;
      end
   end

   assign hi_cnt = hi_cnt_q;
`else
   assign hi_cnt = '0;
`endif

endmodule

// File: tb/tb_nor_gate.sv
// Self-checking bench for nor_gate: a WIDTH=1 instance for the truth table and
// a WIDTH=4 instance driven cycle by cycle against a scoreboard of expected
// registered outputs.
module tb_nor_gate;

   localparam int unsigned CW = 4;

   logic          clk;
   logic          rst;
   logic          a1, b1;
   logic          y1, y_q1, all_one1, y_rise1;
   logic [CW-1:0] hi_cnt1;
   logic [3:0]    a4, b4;
   logic [3:0]    y4, y_q4, y_rise4;
   logic          all_one4;
   logic [CW-1:0] hi_cnt4;

   typedef struct packed {
      logic [3:0]    yq;
      logic [3:0]    rise;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t          sb[$];
   exp_t          e;
   logic [3:0]    m_yq, m_rise;
   logic [CW-1:0] m_cnt;
   int            n_checks;
   int            n_fail;

   nor_gate #(.WIDTH(1), .CNT_W(CW)) u_dut1 (
      .clk(clk), .rst(rst), .a(a1), .b(b1), .y(y1), .y_q(y_q1),
      .all_one(all_one1), .y_rise(y_rise1), .hi_cnt(hi_cnt1)
   );

   nor_gate #(.WIDTH(4), .CNT_W(CW)) u_dut4 (
      .clk(clk), .rst(rst), .a(a4), .b(b4), .y(y4), .y_q(y_q4),
      .all_one(all_one4), .y_rise(y_rise4), .hi_cnt(hi_cnt4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one cycle of stimulus at the falling edge, advance the reference
   // model to what the registers hold after the next rising edge, queue it,
   // and return 1 unit after that edge.
   task automatic drive(input logic [3:0] av, input logic [3:0] bv, input logic r);
      logic [3:0] ym;
      @(negedge clk);
      a4  = av;
      b4  = bv;
      rst = r;
      ym  = ~(av | bv);
      if (r) begin
         m_yq   = 4'h0;
         m_rise = 4'h0;
         m_cnt  = '0;
      end else begin
         m_rise = ym & ~m_yq;
         m_yq   = ym;
`ifdef NOR_GATE_STATS_EN
         if (&ym && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
`endif
      end
      sb.push_back('{yq: m_yq, rise: m_rise, cnt: m_cnt});
      @(posedge clk);
      #1;
   endtask

   task automatic test_truth_table();
      logic [1:0] ab;
      logic       exp_y;
      for (int i = 0; i < 4; i++) begin
         ab    = 2'(i);
         a1    = ab[1];
         b1    = ab[0];
         exp_y = (i == 0) ? 1'b1 : 1'b0;
         #1;
         n_checks++;
         if (y1 !== exp_y || all_one1 !== exp_y) begin
            n_fail++;
            $display("FAIL truth_table a=%b b=%b: y=%b all_one=%b, want %b", a1, b1, y1, all_one1, exp_y);
         end
      end
      // A 1 on either input dominates an unknown on the other.
      a1 = 1'bx; b1 = 1'b1; #1;
      n_checks++;
      if (y1 !== 1'b0) begin
         n_fail++;
         $display("FAIL dominant_b: y=%b, want 0", y1);
      end
      a1 = 1'b1; b1 = 1'bz; #1;
      n_checks++;
      if (y1 !== 1'b0) begin
         n_fail++;
         $display("FAIL dominant_a: y=%b, want 0", y1);
      end
      a1 = 1'b0; b1 = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         drive(4'h0, 4'h0, 1'b1);
         e = sb.pop_front();
         n_checks++;
         if ({y_q4, y_rise4, hi_cnt4} !== e || y_q1 !== 1'b0 || y_rise1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset cyc%0d: y_q=%h y_rise=%h hi_cnt=%h y_q1=%b, want 0", i, y_q4, y_rise4, hi_cnt4, y_q1);
         end
         n_checks++;
         if (y4 !== 4'hF) begin
            n_fail++;
            $display("FAIL y_during_reset: y=%h, want f", y4);
         end
      end
   endtask

   task automatic test_release();
      for (int i = 0; i < 3; i++) begin
         drive(4'h0, 4'h0, 1'b0);
         e = sb.pop_front();
         n_checks++;
         if ({y_q4, y_rise4, hi_cnt4} !== e) begin
            n_fail++;
            $display("FAIL release cyc%0d: got %h/%h/%h want %h/%h/%h", i, y_q4, y_rise4, hi_cnt4, e.yq, e.rise, e.cnt);
         end
      end
      n_checks++;
      if (y_rise4 !== 4'h0 || y_q4 !== 4'hF || y_rise1 !== 1'b0 || y_q1 !== 1'b1) begin
         n_fail++;
         $display("FAIL rise_once: y_q=%h y_rise=%h y_q1=%b y_rise1=%b, want f/0/1/0", y_q4, y_rise4, y_q1, y_rise1);
      end
   endtask

   task automatic test_multi_lane();
      a4 = 4'b0101; b4 = 4'b0011; #1;
      n_checks++;
      if (y4 !== 4'b1000 || all_one4 !== 1'b0) begin
         n_fail++;
         $display("FAIL lanes_mixed: y=%b all_one=%b, want 1000/0", y4, all_one4);
      end
      a4 = 4'h0; b4 = 4'h0; #1;
      n_checks++;
      if (y4 !== 4'hF || all_one4 !== 1'b1) begin
         n_fail++;
         $display("FAIL lanes_zero: y=%h all_one=%b, want f/1", y4, all_one4);
      end
      // Scoreboarded sequence with lanes toggling both ways.
      for (int i = 0; i < 6; i++) begin
         drive((i % 2 == 0) ? 4'b0101 : 4'h0, (i % 3 == 0) ? 4'b0011 : 4'h0, 1'b0);
         e = sb.pop_front();
         n_checks++;
         if ({y_q4, y_rise4, hi_cnt4} !== e || y4 !== ~(a4 | b4)) begin
            n_fail++;
            $display("FAIL lanes_seq cyc%0d: got %h/%h/%h y=%h want %h/%h/%h", i, y_q4, y_rise4, hi_cnt4, y4, e.yq, e.rise, e.cnt);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      drive(4'h0, 4'h0, 1'b0);
      e = sb.pop_front();
      n_checks++;
      if ({y_q4, y_rise4, hi_cnt4} !== e) begin
         n_fail++;
         $display("FAIL mid_pre: got %h/%h/%h want %h/%h/%h", y_q4, y_rise4, hi_cnt4, e.yq, e.rise, e.cnt);
      end
      drive(4'h0, 4'h0, 1'b1);
      e = sb.pop_front();
      n_checks++;
      if ({y_q4, y_rise4, hi_cnt4} !== e || y_q4 !== 4'h0 || y4 !== 4'hF) begin
         n_fail++;
         $display("FAIL mid_reset: y_q=%h y_rise=%h hi_cnt=%h y=%h, want 0/0/0/f", y_q4, y_rise4, hi_cnt4, y4);
      end
      drive(4'h0, 4'h0, 1'b0);
      e = sb.pop_front();
      n_checks++;
      if ({y_q4, y_rise4, hi_cnt4} !== e || y_rise4 !== 4'hF) begin
         n_fail++;
         $display("FAIL mid_release: y_q=%h y_rise=%h, want f/f", y_q4, y_rise4);
      end
   endtask

   task automatic test_stats();
      logic [CW-1:0] want;
`ifdef NOR_GATE_STATS_EN
      want = {CW{1'b1}};
`else
      want = '0;
`endif
      drive(4'h0, 4'h0, 1'b1);
      void'(sb.pop_front());
      for (int i = 0; i < 20; i++) begin
         drive(4'h0, 4'h0, 1'b0);
         e = sb.pop_front();
         n_checks++;
         if ({y_q4, y_rise4, hi_cnt4} !== e) begin
            n_fail++;
            $display("FAIL stats cyc%0d: hi_cnt=%0d want %0d", i, hi_cnt4, e.cnt);
         end
      end
      n_checks++;
      if (hi_cnt4 !== want) begin
         n_fail++;
         $display("FAIL stats_sat: hi_cnt=%0d want %0d", hi_cnt4, want);
      end
      drive(4'h0, 4'h0, 1'b1);
      e = sb.pop_front();
      n_checks++;
      if (hi_cnt4 !== '0 || {y_q4, y_rise4, hi_cnt4} !== e) begin
         n_fail++;
         $display("FAIL stats_clear: hi_cnt=%0d want 0", hi_cnt4);
      end
   endtask

   task automatic test_random();
      logic [3:0] av, bv;
      logic       r;
      for (int i = 0; i < 40; i++) begin
         av = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
         bv = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
         r  = ($urandom_range(0, 9) == 0);
         drive(av, bv, r);
         e = sb.pop_front();
         n_checks++;
         if ({y_q4, y_rise4, hi_cnt4} !== e || y4 !== ~(av | bv)) begin
            n_fail++;
            $display("FAIL random cyc%0d: got %h/%h/%h want %h/%h/%h", i, y_q4, y_rise4, hi_cnt4, e.yq, e.rise, e.cnt);
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      m_yq     = 4'h0;
      m_rise   = 4'h0;
      m_cnt    = '0;
      rst      = 1'b1;
      a1 = 1'b0; b1 = 1'b0;
      a4 = 4'h0; b4 = 4'h0;
      test_truth_table();
      test_reset();
      test_release();
      test_multi_lane();
      test_reset_mid_run();
      test_stats();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
